// File: rtl/halfword_serializer_pkg.sv
// Shared widths, FSM state type and byte-select helper for the half-word
// byte serializer.
package halfword_serializer_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1
    } state_t;

    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                    input logic              high);
        return high ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/halfword_byte_serializer_fifo.sv
// DEPTH x WORD_W synchronous FIFO; push is ignored when full, pop when empty.
// No full-pass-through and no empty bypass.
module halfword_fifo
    import halfword_serializer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only read after count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/halfword_byte_serializer.sv
// Buffers 16-bit words and emits each as two bytes on a valid/ready stream;
// the last byte of a word pops the next one so words flow without a bubble.
module halfword_byte_serializer
    import halfword_serializer_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    output logic              busy
);

    state_t                  state;
    logic [WORD_W-1:0]       hold;
    logic [WORD_W-1:0]       rd_data;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    pop;

    halfword_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (in),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE) || (count != '0);

    // A new word is taken when idle, or on the handshake of the current word's last byte.
    assign pop = !empty && ((state == IDLE) || (state == BYTE1 && out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
        end else if (pop) begin
            state     <= BYTE0;
            hold      <= rd_data;
            out_valid <= 1'b1;
            out_byte  <= pick_byte(rd_data, HI_FIRST);
            out_last  <= 1'b0;
        end else begin
            case (state)
                BYTE0: begin
                    if (out_ready) begin
                        state    <= BYTE1;
                        out_byte <= pick_byte(hold, !HI_FIRST);
                        out_last <= 1'b1;
                    end
                end
                BYTE1: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_halfword_byte_serializer.sv
// Self-checking bench: directed scenarios plus random traffic scored against a
// byte-queue model of the expected output stream.
module tb_halfword_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        busy;

    logic        lo_in_valid;
    logic        lo_in_ready;
    logic [15:0] lo_in;
    logic        lo_out_valid;
    logic        lo_out_ready;
    logic [7:0]  lo_out_byte;
    logic        lo_out_last;
    logic        lo_busy;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q [$];
    logic       stalled = 1'b0;
    logic [9:0] stall_snap;

    always #5 clk = ~clk;

    halfword_byte_serializer #(.DEPTH(2), .HI_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy)
    );

    halfword_byte_serializer #(.DEPTH(2), .HI_FIRST(1'b0)) dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (lo_in_valid),
        .in_ready  (lo_in_ready),
        .in        (lo_in),
        .out_valid (lo_out_valid),
        .out_ready (lo_out_ready),
        .out_byte  (lo_out_byte),
        .out_last  (lo_out_last),
        .busy      (lo_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: every accepted word becomes first byte then second byte (last=1).
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stable", {out_valid, out_last, out_byte}, stall_snap);
            end
            if (out_valid && out_ready) begin
                check("model_q_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("stream_byte", out_byte, e[7:0]);
                    check("stream_last", out_last, e[8]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in[15:8]});
                exp_q.push_back({1'b1, in[7:0]});
            end
            stalled    = out_valid && !out_ready;
            stall_snap = {out_valid, out_last, out_byte};
        end
    end

    initial begin
        logic [7:0] bp_bytes [8];
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in           = '0;
        out_ready    = 1'b0;
        lo_in_valid  = 1'b0;
        lo_in        = '0;
        lo_out_ready = 1'b0;
        bp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        // Reset values
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word, high byte first, latency and return to idle
        in = 16'hA55A; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_lat_valid", out_valid, 1'b0);
        check("single_lat_busy", busy, 1'b1);
        tick();
        check("single_b0_valid", out_valid, 1'b1);
        check("single_b0_byte", out_byte, 8'hA5);
        check("single_b0_last", out_last, 1'b0);
        tick();
        check("single_b1_byte", out_byte, 8'h5A);
        check("single_b1_last", out_last, 1'b1);
        tick();
        check("single_idle_valid", out_valid, 1'b0);
        check("single_idle_busy", busy, 1'b0);

        // Low byte first instance
        lo_in = 16'h1234; lo_in_valid = 1'b1; lo_out_ready = 1'b1;
        tick();
        lo_in_valid = 1'b0;
        tick();
        check("lo_b0_byte", lo_out_byte, 8'h34);
        check("lo_b0_last", lo_out_last, 1'b0);
        tick();
        check("lo_b1_byte", lo_out_byte, 8'h12);
        check("lo_b1_last", lo_out_last, 1'b1);
        tick();
        check("lo_idle_valid", lo_out_valid, 1'b0);

        // Back-pressure: one word in holding register, two buffered, then full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in = {bp_bytes[2*i], bp_bytes[2*i+1]};
            check("bp_in_ready", in_ready, 1'b1);
            tick();
        end
        in = 16'h0708;
        for (int i = 0; i < 3; i++) begin
            check("bp_full_in_ready", in_ready, 1'b0);
            check("bp_held_valid", out_valid, 1'b1);
            check("bp_held_byte", out_byte, 8'h01);
            check("bp_held_last", out_last, 1'b0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic accepted;
            check("bp_contig_valid", out_valid, 1'b1);
            check("bp_contig_byte", out_byte, bp_bytes[i]);
            check("bp_contig_last", out_last, i % 2);
            if (i == 1) check("full_pop_push_refused", in_ready, 1'b0);
            if (i == 2) check("after_pop_in_ready", in_ready, 1'b1);
            accepted = in_valid && in_ready;
            tick();
            if (accepted) in_valid = 1'b0;
        end
        check("bp_end_valid", out_valid, 1'b0);
        check("bp_end_busy", busy, 1'b0);

        // Random traffic against the model
        begin
            int acc = 0;
            int cyc = 0;
            while (acc < 100 && cyc < 5000) begin
                in_valid  = 1'($urandom_range(0, 1));
                in        = 16'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                if (in_valid && in_ready) acc++;
                tick();
                cyc++;
            end
            check("rand_words_accepted", acc, 100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        begin
            int n = 0;
            while ((exp_q.size() != 0 || busy) && n < 200) begin
                tick();
                n++;
            end
            check("rand_drain_in_time", n < 200, 1'b1);
        end
        check("rand_drain_busy", busy, 1'b0);

        // Reset in BYTE1 with one word still buffered
        in = 16'hBEEF; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in = 16'h1111;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_byte", out_byte, 8'hEF);
        check("pre_rst_last", out_last, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_byte", out_byte, 8'h00);
        check("mid_rst_out_last", out_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        in = 16'hCAFE; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_b0", out_byte, 8'hCA);
        tick();
        check("post_rst_b1", out_byte, 8'hFE);
        check("post_rst_b1_last", out_last, 1'b1);
        tick();
        check("post_rst_idle_valid", out_valid, 1'b0);
        check("post_rst_idle_busy", busy, 1'b0);
        check("model_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
